// File: rtl/hs_lane_rx.sv
// Receive-side DDR lane deserializer: hunts for the HS sync byte at either bit
// offset, then emits aligned bytes every 4 bit_clk edges with SoT/EoT framing.
module hs_lane_rx #(
    parameter logic [7:0]  SYNC    = 8'hB8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       bit_clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] d,
    output logic [7:0] data,
    output logic       valid,
    output logic       sot,
    output logic       eot,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        ACTIVE = 2'd2,
        FAIL   = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [15:0] w_reg, w_next;
    logic [1:0]  phase_reg, phase_next;
    logic        offset_reg, offset_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] cnt_sat;
    logic [7:0]  data_next;
    logic        valid_next, sot_next, eot_next, err_next;
    logic [15:0] shifted;
    logic        lock0, lock1;

    // Matching on the post-shift window lets sot leave on the very edge that
    // completes the sync byte instead of one edge later.
    assign shifted = {d[1], d[0], w_reg[15:2]};
    assign lock0   = (shifted[15:8] == SYNC) && (shifted[7:0] == 8'd0);
    assign lock1   = (shifted[14:7] == SYNC) && (shifted[6:0] == 7'd0);
    assign cnt_sat = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

    always_comb begin
        state_next  = state_reg;
        w_next      = shifted;
        phase_next  = phase_reg;
        offset_next = offset_reg;
        cnt_next    = cnt_reg;
        data_next   = data;
        valid_next  = 1'b0;
        sot_next    = 1'b0;
        eot_next    = 1'b0;
        err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                w_next     = 16'd0;
                cnt_next   = 16'd0;
                phase_next = 2'd0;
                if (en) begin
                    state_next = HUNT;
                end
            end
            HUNT: begin
                if (!en) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_sat;
                    if (lock0 || lock1) begin
                        state_next  = ACTIVE;
                        phase_next  = 2'd0;
                        offset_next = !lock0;
                        sot_next    = 1'b1;
                    end else if (cnt_sat >= TIMEOUT_W) begin
                        state_next = FAIL;
                        err_next   = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (!en) begin
                    state_next = IDLE;
                    eot_next   = 1'b1;
                end else begin
                    phase_next = phase_reg + 2'd1;
                    if (phase_reg == 2'd3) begin
                        data_next  = offset_reg ? shifted[14:7] : shifted[15:8];
                        valid_next = 1'b1;
                    end
                end
            end
            FAIL: begin
                if (!en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == IDLE) begin
            data_next = 8'd0;
        end
    end

    always_ff @(posedge bit_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            w_reg      <= 16'd0;
            phase_reg  <= 2'd0;
            offset_reg <= 1'b0;
            cnt_reg    <= 16'd0;
            data       <= 8'd0;
            valid      <= 1'b0;
            sot        <= 1'b0;
            eot        <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_reg  <= state_next;
            w_reg      <= w_next;
            phase_reg  <= phase_next;
            offset_reg <= offset_next;
            cnt_reg    <= cnt_next;
            data       <= data_next;
            valid      <= valid_next;
            sot        <= sot_next;
            eot        <= eot_next;
            err        <= err_next;
        end
    end

endmodule

// File: tb/tb_hs_lane_rx.sv
// Scoreboard bench for hs_lane_rx: stimulus queues expected events stamped with
// the bit_clk edge that must produce them; a negedge monitor pops and compares.
module tb_hs_lane_rx;

    localparam int K_VALID = 0;
    localparam int K_SOT   = 1;
    localparam int K_EOT   = 2;
    localparam int K_ERR   = 3;
    localparam int K_NONE  = -1;

    logic       bit_clk;
    logic       rst_n;
    logic       en;
    logic [1:0] d;
    logic [7:0] data;
    logic       valid, sot, eot, err;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    int         exp_kind[$];
    logic [7:0] exp_data[$];
    int         exp_edge[$];

    logic       bit_q[$];
    int         tag_q[$];
    logic [7:0] tagd_q[$];

    hs_lane_rx #(.SYNC(8'hB8), .TIMEOUT(64)) dut (
        .bit_clk (bit_clk),
        .rst_n   (rst_n),
        .en      (en),
        .d       (d),
        .data    (data),
        .valid   (valid),
        .sot     (sot),
        .eot     (eot),
        .err     (err)
    );

    initial begin
        bit_clk = 1'b0;
        forever #5 bit_clk = ~bit_clk;
    end

    always @(posedge bit_clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic mon(input int kind, input logic [7:0] val);
        int         k;
        logic [7:0] v;
        int         e;
        n_cmp++;
        if (exp_kind.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind %0d data 0x%02h at edge %0d, none required",
                     kind, val, edge_cnt);
        end else begin
            k = exp_kind.pop_front();
            v = exp_data.pop_front();
            e = exp_edge.pop_front();
            if (k != kind || e != edge_cnt || (kind == K_VALID && v != val)) begin
                n_fail++;
                $display("FAIL event: got kind %0d data 0x%02h edge %0d, required kind %0d data 0x%02h edge %0d",
                         kind, val, edge_cnt, k, v, e);
            end else begin
                $display("event kind %0d data 0x%02h edge %0d ok", kind, val, edge_cnt);
            end
        end
    endtask

    always @(negedge bit_clk) begin
        if (rst_n) begin
            if (valid) mon(K_VALID, data);
            if (sot)   mon(K_SOT, 8'h00);
            if (eot)   mon(K_EOT, 8'h00);
            if (err)   mon(K_ERR, 8'h00);
        end
    end

    task automatic expect_ev(input int kind, input logic [7:0] val, input int e);
        exp_kind.push_back(kind);
        exp_data.push_back(val);
        exp_edge.push_back(e);
    endtask

    task automatic drive(input logic e, input logic [1:0] p);
        en = e;
        d  = p;
        @(posedge bit_clk);
        #1;
    endtask

    task automatic push_bit(input logic b);
        bit_q.push_back(b);
        tag_q.push_back(K_NONE);
        tagd_q.push_back(8'h00);
    endtask

    task automatic push_byte(input logic [7:0] b, input int kind);
        for (int i = 0; i < 8; i++) begin
            bit_q.push_back(b[i]);
            tag_q.push_back((i == 7) ? kind : K_NONE);
            tagd_q.push_back(b);
        end
    endtask

    // Serializes queued bits as pairs; a tagged bit means its byte's event is
    // due on the edge that captures that bit.
    task automatic flush_bits();
        logic       b0, b1;
        int         t0, t1;
        logic [7:0] v0, v1;
        while (bit_q.size() > 0) begin
            b0 = bit_q.pop_front();
            t0 = tag_q.pop_front();
            v0 = tagd_q.pop_front();
            if (bit_q.size() > 0) begin
                b1 = bit_q.pop_front();
                t1 = tag_q.pop_front();
                v1 = tagd_q.pop_front();
            end else begin
                b1 = 1'b0;
                t1 = K_NONE;
                v1 = 8'h00;
            end
            drive(1'b1, {b1, b0});
            if (t0 != K_NONE) expect_ev(t0, v0, edge_cnt);
            if (t1 != K_NONE) expect_ev(t1, v1, edge_cnt);
        end
    endtask

    task automatic start_lane();
        drive(1'b1, 2'b00);
    endtask

    task automatic end_lane(input bit active);
        drive(1'b0, 2'b00);
        if (active) expect_ev(K_EOT, 8'h00, edge_cnt);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00);
    endtask

    task automatic drain_check(input string name);
        check(name, exp_kind.size(), 0);
        exp_kind.delete();
        exp_data.delete();
        exp_edge.delete();
    endtask

    initial begin
        int entry;
        rst_n = 1'b0;
        en    = 1'b0;
        d     = 2'b00;
        @(posedge bit_clk);
        #1;
        check("reset_data",  int'(data),  0);
        check("reset_valid", int'(valid), 0);
        check("reset_sot",   int'(sot),   0);
        check("reset_eot",   int'(eot),   0);
        check("reset_err",   int'(err),   0);
        #2 rst_n = 1'b1;
        @(posedge bit_clk);
        #1;
        idle(2);

        // Aligned burst, offset 0
        start_lane();
        push_byte(8'h00, K_NONE);
        push_byte(8'hB8, K_SOT);
        push_byte(8'h12, K_VALID);
        push_byte(8'h34, K_VALID);
        flush_bits();
        end_lane(1);
        idle(3);
        drain_check("drain_offset0");

        // Offset 1: one extra leading zero bit
        start_lane();
        push_bit(1'b0);
        push_byte(8'h00, K_NONE);
        push_byte(8'hB8, K_SOT);
        push_byte(8'h12, K_VALID);
        push_byte(8'h34, K_VALID);
        flush_bits();
        end_lane(1);
        idle(3);
        drain_check("drain_offset1");

        // Hunt timeout, then recovery after one en=0 cycle
        start_lane();
        entry = edge_cnt;
        expect_ev(K_ERR, 8'h00, entry + 64);
        repeat (69) drive(1'b1, 2'b00);
        end_lane(0);
        start_lane();
        push_byte(8'h00, K_NONE);
        push_byte(8'hB8, K_SOT);
        push_byte(8'h5A, K_VALID);
        flush_bits();
        end_lane(1);
        idle(3);
        drain_check("drain_timeout");

        // Missing preamble
        start_lane();
        push_byte(8'hFF, K_NONE);
        push_byte(8'hB8, K_NONE);
        push_byte(8'h55, K_NONE);
        flush_bits();
        end_lane(0);
        idle(3);
        drain_check("drain_no_preamble");

        // Mid-byte end of transmission
        start_lane();
        push_byte(8'h00, K_NONE);
        push_byte(8'hB8, K_SOT);
        push_byte(8'hA5, K_VALID);
        for (int i = 0; i < 4; i++) push_bit(i[0]);
        flush_bits();
        end_lane(1);
        idle(3);
        check("data_cleared_after_eot", int'(data), 0);
        drain_check("drain_midbyte");

        // Asynchronous reset while a byte strobe is being presented
        start_lane();
        push_byte(8'h00, K_NONE);
        push_byte(8'hB8, K_SOT);
        push_byte(8'h3C, K_VALID);
        push_byte(8'hC3, K_NONE);
        flush_bits();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_data",  int'(data),  0);
        check("async_rst_valid", int'(valid), 0);
        check("async_rst_sot",   int'(sot),   0);
        check("async_rst_eot",   int'(eot),   0);
        check("async_rst_err",   int'(err),   0);
        drive(1'b0, 2'b00);
        rst_n = 1'b1;
        idle(1);
        start_lane();
        push_byte(8'h00, K_NONE);
        push_byte(8'hB8, K_SOT);
        push_byte(8'h77, K_VALID);
        flush_bits();
        end_lane(1);
        idle(3);
        drain_check("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_lane_rx.md
# hs_lane_rx

DDR lane deserializer and byte aligner for the receive side of a high-speed serial lane. It is the counterpart of the team's 8:1 DDR serializer. It consumes one bit pair per `bit_clk` edge from an input DDR capture primitive (IDDR, external to this block), hunts for the HS sync byte at either bit offset, and emits aligned bytes with a one-cycle valid strobe every 4 `bit_clk` cycles. Lane framing is supported through start-of-transmission and end-of-transmission pulses, plus a hunt timeout error.

## Interface
- `SYNC`, default 8'hB8: sync byte, transmitted LSB first.
- `TIMEOUT`, default 64: number of `bit_clk` cycles allowed in HUNT before an error is flagged (range 1..65535).
- `bit_clk` in 1: the only clock, the lane bit clock (4 cycles per byte). One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: lane in HS mode, driven by the LP-state detector, synchronous to `bit_clk`.
- `d` in 2: bit pair captured on this edge. `d[0]` is the earlier bit and `d[1]` the later bit.
- `data` out 8: received byte, LSB = first bit on the wire.
- `valid` out 1: one-cycle strobe qualifying `data`.
- `sot` out 1: one-cycle pulse when sync is found.
- `eot` out 1: one-cycle pulse when ACTIVE is left.
- `err` out 1: one-cycle pulse on hunt timeout.

## Operation
- Window register `w[15:0]`:
  - Shifts each edge: `w <= {d[1], d[0], w[15:2]}`. Newest bit is at `w[15]`, oldest at `w[0]`.
  - Cleared to 0 in IDLE.
- State machine: IDLE, HUNT, ACTIVE, FAIL.
- IDLE:
  - Stays while `en`=0.
  - Moves to HUNT when `en`=1.
  - Timeout counter is cleared.
- HUNT:
  - Lock at offset 0 when `w[15:8]==SYNC` and `w[7:0]==0`.
  - Lock at offset 1 when `w[14:7]==SYNC` and `w[6:0]==0`.
  - Offset 0 wins if both match.
  - On lock: go to ACTIVE, set `phase`=0, pulse `sot`.
  - Timeout counter (16-bit, saturating) increments every HUNT cycle. When it reaches TIMEOUT with no lock: pulse `err`, go to FAIL.
- FAIL:
  - No hunting and no output.
  - Leaves to IDLE only when `en`=0.
- ACTIVE:
  - 2-bit `phase` increments every edge and wraps 3→0.
  - When `phase` wraps to 0, the byte is taken from the window: `w[15:8]` for offset 0, `w[14:7]` for offset 1. It is registered into `data` together with `valid`=1.
- `en`=0 in any state forces IDLE on the next edge:
  - From ACTIVE, `eot` pulses and any partial byte is discarded (no `valid`).
  - From HUNT or FAIL, no pulse is produced.
- `en` and the lock match in the same cycle while in IDLE: no lock; the block enters HUNT first.
- `data` holds its last value between strobes and is cleared to 0 on IDLE entry.

## Timing
- Reset: while `rst_n` is low, immediately and asynchronously:
  - state=IDLE;
  - `w`, `phase`, offset and counter are 0;
  - `data`=0, `valid`=0, `sot`=0, `eot`=0, `err`=0.
- All outputs are registered.
- `sot` is high in the cycle after the edge that shifted the sync byte's final bit into `w`.
- First `valid` comes exactly 4 edges after the `sot` edge. Subsequent strobes follow every 4 edges.
- Byte latency: `valid` is high in the cycle after the edge capturing the byte's final bit pair.
- `eot` is high in the cycle after the edge that samples `en`=0 in ACTIVE.
- `err` is high in the cycle after the edge on which the counter reaches TIMEOUT, i.e. TIMEOUT edges after HUNT entry.
- `valid`, `sot`, `eot` and `err` are never high for 2 consecutive cycles.

## Test plan
- Aligned burst, offset 0:
  - Stimulus: `en`=1, 4 zero pairs, then SYNC (B8), 0x12, 0x34 serialized LSB-first as pairs.
  - Required: `sot` once; `valid` with `data`=0x12, then 4 cycles later `valid` with `data`=0x34.
- Offset 1:
  - Stimulus: same stream preceded by a single extra 0 bit.
  - Required: identical `sot`/`data` sequence, with each event one edge later or at the same edge as offset parity dictates.
- Timeout:
  - Stimulus: `en`=1 with zeros for 70 cycles.
  - Required: `err` pulses exactly once after 64 edges in HUNT; no `valid`/`sot`.
  - Then `en`=0 for 1 cycle and `en`=1 with a valid burst: lock succeeds.
- Missing preamble:
  - Stimulus: 0xFF, then 0xB8, then 0x55.
  - Required: no `sot`, no `valid`.
- Mid-byte end:
  - Stimulus: lock, send 0xA5, then 2 pairs of the next byte, then `en`=0.
  - Required: `valid`/0xA5 once, `eot` one cycle after `en` is sampled low, no further `valid`, `data`=0 thereafter.
- Async reset mid-burst:
  - Stimulus: drop `rst_n` between clock edges during ACTIVE.
  - Required: all outputs 0 immediately; after release with `en`=1, a fresh burst locks normally.
